sr04_controller: RTL and testbench

- Drives an HC-SR04 ultrasonic sensor: issues the trigger pulse, times the echo, and converts echo width to whole centimetres.
- Produces a 9-bit distance plus a one-cycle done pulse.
- Sits directly upstream of the ASCII distance formatter, which consumes dist_data/sr04_done and pushes "DIST:nnnCM" into the UART TX FIFO.

---
 rtl/sr04_controller.sv | 169 ++++++++++++++++
 tb/tb_sr04_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr04_controller.sv
// HC-SR04 ultrasonic ranging controller.
// Issues a trigger pulse, times the echo-high interval in microseconds and
// converts it to whole centimetres (saturating at MAX_CM). A one-cycle
// sr04_done pulse marks a fresh dist_data. timeout_err pulses when no echo
// arrives in time. A cooldown gap separates consecutive measurements.
`timescale 1ns/1ps

module sr04_controller #(
  parameter int CLK_PER_US  = 100,
  parameter int TRIG_US     = 10,
  parameter int US_PER_CM   = 58,
  parameter int MAX_CM      = 400,
  parameter int TIMEOUT_US  = 30000,
  parameter int COOLDOWN_US = 60000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       echo,
  output logic       trig,
  output logic [8:0] dist_data,
  output logic       sr04_done,
  output logic       timeout_err,
  output logic       busy
);

  // Microsecond counter must hold the longest per-state limit.
  localparam int MAX_US_A = (TIMEOUT_US > COOLDOWN_US) ? TIMEOUT_US : COOLDOWN_US;
  localparam int MAX_US   = (MAX_US_A > TRIG_US) ? MAX_US_A : TRIG_US;
  localparam int US_W     = $clog2(MAX_US + 1);
  localparam int PS_W     = $clog2(CLK_PER_US + 1);
  localparam int FR_W     = $clog2(US_PER_CM + 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEAS,
    DONE,
    COOLDOWN
  } state_t;

  state_t          state, state_next;
  logic [PS_W-1:0] presc;
  logic [US_W-1:0] us_cnt;
  logic [US_W-1:0] us_limit;
  logic            us_tick;
  logic            at_limit;
  logic            echo_s1, echo_s2, echo_s3;
  logic            rise, fall;
  logic [FR_W-1:0] frac;
  logic [8:0]      cm;

  assign us_tick  = (presc == PS_W'(CLK_PER_US - 1));
  assign at_limit = us_tick && (us_cnt == us_limit);
  assign rise     = echo_s2 & ~echo_s3;
  assign fall     = ~echo_s2 & echo_s3;
  assign busy     = (state != IDLE);

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // update together from the values present before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and the microsecond limit of the current state.
  // NOTE: defaults are assigned first so no path leaves a signal unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    us_limit   = '0;
    case (state)
      IDLE: begin
        if (start) state_next = TRIG;
      end
      TRIG: begin
        us_limit = US_W'(TRIG_US - 1);
        if (at_limit) state_next = WAIT_ECHO;
      end
      WAIT_ECHO: begin
        us_limit = US_W'(TIMEOUT_US - 1);
        // A rise in the expiry cycle still counts as an echo.
        if (rise)          state_next = MEAS;
        else if (at_limit) state_next = COOLDOWN;
      end
      MEAS: begin
        us_limit = US_W'(TIMEOUT_US - 1);
        if (fall || at_limit) state_next = DONE;
      end
      DONE: begin
        state_next = COOLDOWN;
      end
      COOLDOWN: begin
        us_limit = US_W'(COOLDOWN_US - 1);
        if (at_limit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Prescaler and per-state microsecond count, realigned on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      us_cnt <= '0;
    end else if (state_next != state) begin
      presc  <= '0;
      us_cnt <= '0;
    end else if (us_tick) begin
      presc  <= '0;
      us_cnt <= us_cnt + US_W'(1);
    end else begin
      presc  <= presc + PS_W'(1);
    end
  end

  // Echo synchroniser plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_s3 <= 1'b0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
    end
  end

  // Echo-width to centimetre conversion; an echo-high timeout forces MAX_CM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frac <= '0;
      cm   <= '0;
    end else if (state != MEAS && state_next == MEAS) begin
      frac <= '0;
      cm   <= '0;
    end else if (state == MEAS) begin
      if (at_limit) begin
        cm <= 9'(MAX_CM);
      end else if (us_tick) begin
        if (frac == FR_W'(US_PER_CM - 1)) begin
          frac <= '0;
          if (cm < 9'(MAX_CM)) cm <= cm + 9'd1;
        end else begin
          frac <= frac + FR_W'(1);
        end
      end
    end
  end

  // Registered outputs: trigger, result capture and the two status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig        <= 1'b0;
      dist_data   <= '0;
      sr04_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      trig        <= (state_next == TRIG);
      sr04_done   <= (state == DONE);
      timeout_err <= (state == WAIT_ECHO) && !rise && at_limit;
      if (state == DONE) dist_data <= cm;
    end
  end

endmodule

// File: tb/tb_sr04_controller.sv
// Self-checking bench for sr04_controller: table-driven measurements with
// hand-derived results, randomized echo widths checked against an arithmetic
// distance model, and sequences for held start and reset mid-measurement.
`timescale 1ns/1ps

module tb_sr04_controller;

  localparam int CLK_PER_US  = 10;
  localparam int TRIG_US     = 10;
  localparam int US_PER_CM   = 58;
  localparam int MAX_CM      = 11;
  localparam int TIMEOUT_US  = 700;
  localparam int COOLDOWN_US = 100;
  localparam int IDLE_LIMIT  = (TIMEOUT_US + COOLDOWN_US + 20) * CLK_PER_US;

  logic       clk, rst, start, echo;
  logic       trig, sr04_done, timeout_err, busy;
  logic [8:0] dist_data;

  sr04_controller #(
    .CLK_PER_US (CLK_PER_US),
    .TRIG_US    (TRIG_US),
    .US_PER_CM  (US_PER_CM),
    .MAX_CM     (MAX_CM),
    .TIMEOUT_US (TIMEOUT_US),
    .COOLDOWN_US(COOLDOWN_US)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .echo       (echo),
    .trig       (trig),
    .dist_data  (dist_data),
    .sr04_done  (sr04_done),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Event monitor, sampled on the falling edge.
  int cyc = 0;
  int done_cnt = 0, to_cnt = 0, both_cnt = 0, trig_rises = 0;
  int done_cyc = 0, to_cyc = 0, trig_start_cyc = 0, trig_fall_cyc = 0;
  int trig_len = 0, busy_fall_cyc = 0;
  logic trig_q = 1'b0, busy_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sr04_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (timeout_err) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
    if (sr04_done && timeout_err) both_cnt <= both_cnt + 1;
    if (trig && !trig_q) begin
      trig_rises     <= trig_rises + 1;
      trig_start_cyc <= cyc;
    end
    if (!trig && trig_q) begin
      trig_len      <= cyc - trig_start_cyc;
      trig_fall_cyc <= cyc;
    end
    if (!busy && busy_q) busy_fall_cyc <= cyc;
    trig_q <= trig;
    busy_q <= busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance to just after the falling edge, once the monitor has updated.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Distance the sensor should report for an echo of w microseconds.
  function automatic int model_cm(input int w);
    int q;
    if (w >= TIMEOUT_US) return MAX_CM;
    q = w / US_PER_CM;
    return (q > MAX_CM) ? MAX_CM : q;
  endfunction

  task automatic wait_trig_done(input string name, input int r0);
    int n = 0;
    while (!(trig_rises > r0 && !trig) && n < 3000) begin
      step();
      n++;
    end
    check({name, " trig_seen"}, n < 3000, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < IDLE_LIMIT) begin
      step();
      n++;
    end
    check({name, " idle_reached"}, n < IDLE_LIMIT, 1);
  endtask

  // One start-pulse measurement. width_us == 0 leaves echo low throughout.
  task automatic run(input string name, input int delay_cyc, input int width_us,
                     input int exp_dist, input bit exp_done, input bit exp_to,
                     input bit mid_start);
    int d0 = done_cnt;
    int t0 = to_cnt;
    int r0 = trig_rises;
    int c0 = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_trig_done(name, r0);
    check({name, " trig_len"}, trig_len, TRIG_US * CLK_PER_US);
    if (width_us > 0) begin
      repeat (delay_cyc) step();
      echo = 1'b1;
      for (int i = 0; i < width_us * CLK_PER_US; i++) begin
        start = mid_start && (i == width_us * CLK_PER_US / 2);
        step();
      end
      start = 1'b0;
      echo  = 1'b0;
      c0    = cyc;
    end
    wait_idle(name);
    repeat (20) step();
    check({name, " dist_data"}, dist_data, exp_dist);
    check({name, " done_pulses"}, done_cnt - d0, exp_done);
    check({name, " timeout_pulses"}, to_cnt - t0, exp_to);
    check({name, " trig_count"}, trig_rises - r0, 1);
    if (exp_done && width_us <= TIMEOUT_US)
      check({name, " done_latency"}, done_cyc - c0, 4);
    if (exp_done)
      check({name, " cooldown_after_done"}, busy_fall_cyc - done_cyc, COOLDOWN_US * CLK_PER_US);
    if (exp_to) begin
      check({name, " timeout_point"}, to_cyc - trig_fall_cyc, TIMEOUT_US * CLK_PER_US);
      check({name, " cooldown_after_timeout"}, busy_fall_cyc - to_cyc, COOLDOWN_US * CLK_PER_US);
    end
  endtask

  // start held high: each run retriggers one cycle after cooldown ends.
  task automatic start_held();
    int r0 = trig_rises;
    int t0 = to_cnt;
    int d0;
    int n;
    start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_trig_done("held", r0 + k);
      if (k == 1) check("held retrigger_gap", trig_start_cyc - busy_fall_cyc, 1);
      repeat (50) step();
      d0   = done_cnt;
      echo = 1'b1;
      repeat (116 * CLK_PER_US) step();
      echo = 1'b0;
      n = 0;
      while (done_cnt == d0 && n < 50) begin
        step();
        n++;
      end
      check("held done_pulses", done_cnt - d0, 1);
      check("held dist_data", dist_data, 2);
      if (k == 1) start = 1'b0;
    end
    wait_idle("held");
    repeat (20) step();
    check("held trig_count", trig_rises - r0, 2);
    check("held timeout_pulses", to_cnt - t0, 0);
  endtask

  // Reset 200 us into the echo aborts silently; the next run is normal.
  task automatic reset_mid_meas();
    int d0 = done_cnt;
    int t0 = to_cnt;
    int r0 = trig_rises;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_trig_done("rst_mid", r0);
    repeat (50) step();
    echo = 1'b1;
    repeat (200 * CLK_PER_US) step();
    #2 rst = 1'b1;
    #1;
    check("rst_mid trig", trig, 0);
    check("rst_mid busy", busy, 0);
    check("rst_mid dist_data", dist_data, 0);
    check("rst_mid sr04_done", sr04_done, 0);
    echo = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();
    check("rst_mid done_pulses", done_cnt - d0, 0);
    check("rst_mid timeout_pulses", to_cnt - t0, 0);
    run("after_reset", 30, 115, 1, 1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    string name;
    int    delay_cyc;
    int    width_us;
    int    exp_dist;
    bit    exp_done;
    bit    exp_to;
    bit    mid_start;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int w;
    int d;

    // Expected distances: floor(width / 58), clamped to 11, or 11 on echo timeout.
    vecs[0] = '{"normal_580",      500,  580, 10, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{"no_echo",           0,    0, 10, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"floor_57",        200,   57,  0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"floor_115",       100,  115,  1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"saturate_697",    300,  697, 11, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{"floor_57b",        50,   57,  0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{"stuck_high_750",  100,  750, 11, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{"exact_58",         40,   58,  1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{"fall_at_timeout",  60,  700, 11, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{"rise_at_timeout", 6997,  58,  1, 1'b1, 1'b0, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    echo  = 1'b0;
    repeat (3) step();
    check("reset trig", trig, 0);
    check("reset dist_data", dist_data, 0);
    check("reset sr04_done", sr04_done, 0);
    check("reset timeout_err", timeout_err, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 10; i++)
      run(vecs[i].name, vecs[i].delay_cyc, vecs[i].width_us, vecs[i].exp_dist,
          vecs[i].exp_done, vecs[i].exp_to, vecs[i].mid_start);

    for (int i = 0; i < 4; i++) begin
      w = $urandom_range(400, 1);
      d = $urandom_range(300, 0);
      run("random", d, w, model_cm(w), 1'b1, 1'b0, 1'b0);
    end

    start_held();
    reset_mid_meas();

    check("never_done_and_timeout_together", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
